// File: rtl/fpadd_share_arb_pkg.sv
// fpadd_arb_pkg: shared constants, FSM state type and width helper for the adder-sharing arbiter
package fpadd_arb_pkg;
  localparam int FP_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  // Index width that never collapses to zero bits for single-entry cases
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fpadd_share_arb_if.sv
// fpadd_share_arb_if: requester/consumer bus of the adder-sharing arbiter
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake (slice i = [32*i+:32])
//   rsp_valid/rsp_ready/rsp_data/rsp_flag/rsp_id : tagged result handshake
//   master = requester/consumer side, slave = arbiter side
interface fpadd_share_arb_if import fpadd_arb_pkg::*; #(parameter int N_REQ = 4);
  localparam int ID_W = id_w(N_REQ);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [FP_W-1:0]       rsp_data;
  logic                  rsp_flag;
  logic [ID_W-1:0]       rsp_id;
  modport master (output req_valid, req_a, req_b, rsp_ready,
                  input  req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id);
  modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                  output req_ready, rsp_valid, rsp_data, rsp_flag, rsp_id);
endinterface

// File: rtl/fpadd_share_arb_rr_pick.sv
// fpadd_rr_pick: combinational round-robin picker
//   req_i : request vector     ptr_i : highest-priority index
//   any_o : some request set   gnt_o : one-hot grant   idx_o : granted index
module fpadd_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic             any_o,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);
  // Rotate so bit k of dbl is request (ptr+k) mod N; lowest set bit wins
  logic [2*N_REQ-1:0] dbl;
  assign dbl   = {req_i, req_i} >> ptr_i;
  assign any_o = |req_i;
  assign gnt_o = any_o ? N_REQ'(1) << idx_o : '0;
  always_comb begin
    idx_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (dbl[i]) idx_o = ID_W'((int'(ptr_i) + i) % N_REQ);
  end
endmodule

// File: rtl/fpadd_share_arb.sv
// fpadd_share_arb: round-robin sequencer sharing one FP adder among N_REQ requesters
//   CLK, RST (async, active-low)
//   bus       : requester/consumer handshake (slave modport)
//   add_a/add_b/add_en -> adder, add_out/add_flag <- adder (ADD_LAT cycles after EN edge)
//   busy      : high outside IDLE
//   grant_cnt : per-requester saturating grant counters, CNT_W each; live only
//               when FPADD_ARB_STATS_EN is defined, otherwise tied to 0
module fpadd_share_arb import fpadd_arb_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  fpadd_share_arb_if.slave       bus,
  output logic [FP_W-1:0]        add_a,
  output logic [FP_W-1:0]        add_b,
  output logic                   add_en,
  input  logic [FP_W-1:0]        add_out,
  input  logic                   add_flag,
  output logic                   busy,
  output logic [N_REQ*CNT_W-1:0] grant_cnt
);
  localparam int ID_W = id_w(N_REQ);
  localparam int WC_W = id_w(ADD_LAT);
  state_e state_q, state_d;
  logic [ID_W-1:0] ptr_q, id_q, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic pick_any, grant, flag_q;
  logic [FP_W-1:0] a_q, b_q, data_q, sel_a, sel_b;
  logic [WC_W-1:0] wait_q;
  fpadd_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_i(bus.req_valid), .ptr_i(ptr_q), .any_o(pick_any), .gnt_o(pick_gnt), .idx_o(pick_idx)
  );
  assign grant         = state_q == IDLE && pick_any;
  // Gated by RST so nothing is accepted while reset is held
  assign bus.req_ready = (state_q == IDLE && RST) ? pick_gnt : '0;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flag  = flag_q;
  assign bus.rsp_id    = id_q;
  assign add_a         = a_q;
  assign add_b         = b_q;
  assign add_en        = state_q == ISSUE || state_q == WAIT;
  assign busy          = state_q != IDLE;
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_gnt[i]) begin
        sel_a = bus.req_a[i*FP_W +: FP_W];
        sel_b = bus.req_b[i*FP_W +: FP_W];
      end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_any ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = wait_q == '0 ? RESP : WAIT;
      RESP:    state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flag_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        a_q   <= sel_a;
        b_q   <= sel_b;
        id_q  <= pick_idx;
        ptr_q <= ID_W'((int'(pick_idx) + 1) % N_REQ);
      end
      if (state_q == ISSUE) wait_q <= WC_W'(ADD_LAT - 1);
      else if (state_q == WAIT && wait_q != '0) wait_q <= wait_q - 1'b1;
      if (state_q == WAIT && wait_q == '0) begin
        data_q <= add_out;
        flag_q <= add_flag;
      end
    end
`ifdef FPADD_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_W-1:0] cnt_q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) cnt_q <= '0;
    else
      for (int i = 0; i < N_REQ; i++)
        if (grant && pick_gnt[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + 1'b1;
  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_fpadd_share_arb.sv
// tb_fpadd_share_arb: directed + random checks of the adder-sharing arbiter against a behavioural model
module tb_fpadd_share_arb;
  import fpadd_arb_pkg::*;
  logic CLK = 1'b0, RST = 1'b0;
  logic [31:0] add_a, add_b;
  logic [31:0] add_out = '0;
  logic add_flag = 1'b0;
  logic add_en, busy;
  logic [15:0] grant_cnt;
  int total = 0, bad = 0, ptr_m = 0, last_id = 0;
  int gcnt[4];
  logic [31:0] last_data;
  logic [31:0] opa[4], opb[4];

  fpadd_share_arb_if #(.N_REQ(4)) bus();
  fpadd_share_arb #(.N_REQ(4), .ADD_LAT(1), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .bus(bus), .add_a(add_a), .add_b(add_b), .add_en(add_en),
    .add_out(add_out), .add_flag(add_flag), .busy(busy), .grant_cnt(grant_cnt)
  );

  always #5 CLK = ~CLK;

  // Truncating adder for positive normal operands; flag = mantissa carry-out
  function automatic logic [32:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [7:0] e;
    logic [24:0] s;
    a = x[30:23] >= y[30:23] ? x : y;
    b = x[30:23] >= y[30:23] ? y : x;
    e = a[30:23];
    s = {2'b01, a[22:0]} + ({2'b01, b[22:0]} >> (a[30:23] - b[30:23]));
    return s[24] ? {1'b1, 1'b0, e + 8'd1, s[23:1]} : {1'b0, 1'b0, e, s[22:0]};
  endfunction

  // Registered shared adder, one cycle after an EN-high edge
  always @(posedge CLK) if (add_en) {add_flag, add_out} <= fadd(add_a, add_b);

  function automatic logic [31:0] rnd_op();
    return {1'b0, 8'(120 + $urandom_range(0, 15)), 23'($urandom)};
  endfunction

  function automatic int pick(input logic [3:0] v);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (ptr_m + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [15:0] exp_cnt();
    logic [15:0] r;
    r = '0;
`ifdef FPADD_ARB_STATS_EN
    for (int i = 0; i < 4; i++) r[4*i +: 4] = gcnt[i] > 15 ? 4'hF : 4'(gcnt[i]);
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[32*i +: 32] = opa[i];
      bus.req_b[32*i +: 32] = opb[i];
    end
  endtask

  task automatic model_reset();
    ptr_m = 0;
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
  endtask

  // One full operation starting in IDLE at posedge+1; returns at posedge+1 back in IDLE
  task automatic txn(input logic [3:0] v, input int hold);
    int g;
    logic [32:0] r;
    logic [31:0] ea, eb;
    bus.req_valid = v;
    drive_ops();
    #1;
    g = pick(v);
    ea = opa[g];
    eb = opb[g];
    r = fadd(ea, eb);
    chk("cnt", grant_cnt, exp_cnt());
    chk("grant", bus.req_ready, 4'b0001 << g);
    chk("idle_busy", {busy, add_en, bus.rsp_valid}, 3'b000);
    ptr_m = (g + 1) % 4;
    gcnt[g]++;
    @(posedge CLK); #1;
    opa[g] = rnd_op();
    opb[g] = rnd_op();
    drive_ops();
    chk("issue", {add_en, busy, bus.rsp_valid, bus.req_ready}, 7'b1100000);
    chk("issue_a", add_a, ea);
    chk("issue_b", add_b, eb);
    @(posedge CLK); #1;
    chk("wait", {add_en, busy, bus.rsp_valid, bus.req_ready}, 7'b1100000);
    chk("wait_a", add_a, ea);
    @(posedge CLK); #1;
    bus.rsp_ready = hold == 0;
    chk("resp", {bus.rsp_valid, add_en, busy}, 3'b101);
    chk("rsp_data", bus.rsp_data, r[31:0]);
    chk("rsp_flag", bus.rsp_flag, r[32]);
    chk("rsp_id", bus.rsp_id, g);
    last_id = int'(bus.rsp_id);
    last_data = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1;
      if (i == hold - 1) bus.rsp_ready = 1'b1;
      chk("hold_state", {bus.rsp_valid, busy, bus.req_ready}, 6'b110000);
      chk("hold_data", {bus.rsp_id, bus.rsp_flag, bus.rsp_data}, {2'(g), r[32], r[31:0]});
    end
    @(posedge CLK); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      opa[i] = rnd_op();
      opb[i] = rnd_op();
    end
    drive_ops();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ctl", {bus.req_ready, bus.rsp_valid, add_en, busy, bus.rsp_flag, bus.rsp_id}, 0);
    chk("rst_data", {bus.rsp_data, add_a}, 0);
    chk("rst_cnt", grant_cnt, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    // all requesters valid from reset: strict rotation
    for (int k = 0; k < 5; k++) begin
      txn(4'b1111, 0);
      chk("t2_order", last_id, k % 4);
    end
    // known sum 1.0 + 2.0
    opa[0] = 32'h3F800000;
    opb[0] = 32'h40000000;
    txn(4'b0001, 0);
    chk("t1_data", last_data, 32'h40400000);
    chk("t1_id", last_id, 0);
    // consumer stalls five cycles
    txn(4'b1111, 5);
    // pointer lands on 3 after granting 2
    txn(4'b0100, 0);
    txn(4'b1010, 0);
    chk("t5_first", last_id, 3);
    txn(4'b1010, 0);
    chk("t5_second", last_id, 1);
    // random request patterns and stalls
    repeat (40) txn(4'($urandom_range(1, 15)), $urandom_range(0, 2));
    // reset while waiting on the adder
    bus.req_valid = 4'b0001;
    #1;
    chk("t4_grant", bus.req_ready, 4'b0001);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("t4_wait", {add_en, busy}, 2'b11);
    RST = 1'b0;
    #1;
    chk("t4_rst_ctl", {bus.req_ready, bus.rsp_valid, add_en, busy, bus.rsp_flag, bus.rsp_id}, 0);
    chk("t4_rst_data", {bus.rsp_data, add_a}, 0);
    chk("t4_rst_b", add_b, 0);
    chk("t4_rst_cnt", grant_cnt, 0);
    model_reset();
    bus.req_valid = '0;
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
      chk("t4_quiet", {bus.rsp_valid, busy, bus.req_ready}, 0);
    end
    txn(4'b1111, 0);
    chk("t4_regrant", last_id, 0);
    // saturation of requester 2 counter
    repeat (20) txn(4'b0100, 0);
    chk("t6_cnt", grant_cnt, exp_cnt());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
